// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - CPU write path and display pins of the seven-segment scan controller
// blink_mask exists only when SEG_BLINK_EN is defined.
interface seg_scan_ctrl_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  dp_mask;
  logic        lzb;
  logic        disp_on;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif
  logic        upd_pending;
  logic        frame_tick;
  logic [3:0]  segan_en;
  logic [7:0]  segans;

  modport master (
    output wr_en, wr_data, dp_mask, lzb, disp_on,
`ifdef SEG_BLINK_EN
    output blink_mask,
`endif
    input  upd_pending, frame_tick, segan_en, segans
  );

  modport slave (
    input  wr_en, wr_data, dp_mask, lzb, disp_on,
`ifdef SEG_BLINK_EN
    input  blink_mask,
`endif
    output upd_pending, frame_tick, segan_en, segans
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller with frame-synchronous value update
// Define SEG_BLINK_EN to add per-digit blinking driven by blink_mask.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 32
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);
  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  generate
    if (SCAN_DIV < 2 || BLANK_CYC < 0 || BLANK_CYC >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_bad_params
      $error("seg_scan_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   disp;
  logic          pending;
  logic          boundary;

  assign boundary = (idx == 2'd3) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      disp    <= 16'h0000;
      pending <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A write landing on the boundary itself bypasses the shadow entirely.
      if (boundary) begin
        if (bus.wr_en) begin
          disp    <= bus.wr_data;
          pending <= 1'b0;
        end else if (pending) begin
          disp    <= shadow;
          pending <= 1'b0;
        end
      end else if (bus.wr_en) begin
        shadow  <= bus.wr_data;
        pending <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic       slot_live;
  logic [3:0] blink_kill;

  // The first BLANK_CYC cycles of each slot keep all anodes off to avoid ghosting.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign slot_live = 1'b1;
    end else begin : g_blank
      assign slot_live = (cnt >= CW'(BLANK_CYC));
    end
  endgenerate

`ifdef SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (boundary) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_kill = blink_on ? 4'b0000 : bus.blink_mask;
`else
  assign blink_kill = 4'b0000;
`endif

  logic [3:0] nib;
  logic       lead_zero;
  logic [3:0] en_sel;
  logic [7:0] seg_out;

  always_comb begin
    nib = disp[{idx, 2'b00} +: 4];
    // A digit is a leading zero when it and every digit to its left are zero.
    case (idx)
      2'd3:    lead_zero = (disp[15:12] == 4'h0);
      2'd2:    lead_zero = (disp[15:8] == 8'h00);
      2'd1:    lead_zero = (disp[15:4] == 12'h000);
      default: lead_zero = 1'b0;
    endcase
    seg_out = {bus.dp_mask[idx], (bus.lzb && lead_zero) ? 7'h00 : hex_to_seg(nib)};
    en_sel  = (bus.disp_on && slot_live) ? (4'b0001 << idx) : 4'b0000;
  end

  assign bus.segan_en    = en_sel & ~blink_kill;
  assign bus.segans      = seg_out;
  assign bus.frame_tick  = boundary;
  assign bus.upd_pending = pending;
endmodule
